// File: rtl/ram_dumper_pkg.sv
// rtl/ram_dumper_pkg.sv - shared state encoding and defaults for the RAM read-back engine
package ram_dumper_pkg;

  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/ram_dumper.sv
// rtl/ram_dumper.sv - walks an address range of the SAP-1 RAM and streams each word with its address
module ram_dumper
  import ram_dumper_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_debug,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_first_address,
  input  logic [ADDR_WIDTH-1:0] i_last_address,
  output logic [ADDR_WIDTH-1:0] o_ram_address,
  output logic                  o_ram_read_enable,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_checksum
);

  localparam logic [ADDR_WIDTH-1:0] LAST_LEGAL = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   last_q, last_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   checksum_q, checksum_d;
  logic                    valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   last_clamped;
  logic                    handshake;

  // Debug printing lives in the bench; the pin is kept for interface compatibility.
  logic unused_debug;
  assign unused_debug = i_debug;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    last_d       = last_q;
    ram_addr_d   = ram_addr_q;
    address_d    = address_q;
    data_d       = data_q;
    checksum_d   = checksum_q;
    valid_d      = valid_q;
    last_clamped = (i_last_address > LAST_LEGAL) ? LAST_LEGAL : i_last_address;
    handshake    = valid_q && i_ready;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          addr_d     = i_first_address;
          last_d     = last_clamped;
          checksum_d = '0;
          state_d    = (i_first_address > last_clamped) ? DONE : READ;
        end
      end
      READ: begin
        ram_addr_d = addr_q;
        data_d     = i_ram_data;
        address_d  = addr_q;
        valid_d    = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (handshake) begin
          valid_d    = 1'b0;
          checksum_d = checksum_q + data_q;
          if (addr_q == last_q) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over a same-cycle handshake so a cancelled word never reaches the checksum.
    if (i_abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      valid_d    = 1'b0;
      checksum_d = checksum_q;
      addr_d     = addr_q;
      data_d     = data_q;
      address_d  = address_q;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      ram_addr_q <= '0;
      address_q  <= '0;
      data_q     <= '0;
      checksum_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      ram_addr_q <= ram_addr_d;
      address_q  <= address_d;
      data_q     <= data_d;
      checksum_q <= checksum_d;
      valid_q    <= valid_d;
    end
  end

  assign o_ram_address     = (state_q == READ) ? addr_q : ram_addr_q;
  assign o_ram_read_enable = (state_q == READ);
  assign o_data            = data_q;
  assign o_address         = address_q;
  assign o_valid           = valid_q;
  assign o_busy            = (state_q != IDLE);
  assign o_done            = (state_q == DONE);
  assign o_checksum        = checksum_q;

endmodule

// File: tb/tb_ram_dumper.sv
// tb/tb_ram_dumper.sv - directed bench with a range/queue model of the RAM dump stream
module tb_ram_dumper;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } word_t;

  logic        clk = 1'b0;
  logic        i_reset, i_debug, i_start, i_abort, i_ready;
  logic [7:0]  i_first_address, i_last_address;
  logic [7:0]  o_ram_address, o_address;
  logic        o_ram_read_enable, o_valid, o_busy, o_done;
  logic [15:0] ram_data, o_data, o_checksum;

  logic [15:0] ram [16];
  word_t       exp_q[$];
  logic [15:0] model_sum;
  logic        done_due;
  logic        chk_en;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  ram_dumper dut (
    .i_clock(clk), .i_reset(i_reset), .i_debug(i_debug), .i_start(i_start), .i_abort(i_abort),
    .i_first_address(i_first_address), .i_last_address(i_last_address),
    .o_ram_address(o_ram_address), .o_ram_read_enable(o_ram_read_enable), .i_ram_data(ram_data),
    .o_data(o_data), .o_address(o_address), .o_valid(o_valid), .i_ready(i_ready),
    .o_busy(o_busy), .o_done(o_done), .o_checksum(o_checksum)
  );

  always_comb begin
    ram_data = 16'hDEAD;
    if (o_ram_address < 8'd16) ram_data = ram[o_ram_address[3:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Stream scoreboard: every visible word must be the head of the expected range.
  always @(negedge clk) begin
    logic nxt;
    if (chk_en) begin
      nxt = 1'b0;
      chk("done", 32'(o_done), 32'(done_due));
      chk("checksum", 32'(o_checksum), 32'(model_sum));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'(o_valid), 32'd0);
        end else begin
          chk("word_addr", 32'(o_address), 32'(exp_q[0].a));
          chk("word_data", 32'(o_data), 32'(exp_q[0].d));
          if (i_ready) begin
            model_sum = model_sum + exp_q[0].d;
            void'(exp_q.pop_front());
            nxt = (exp_q.size() == 0);
          end
        end
      end
      done_due = nxt;
    end
  end

  task automatic begin_dump(input logic [7:0] first, input logic [7:0] last, input logic rdy);
    int hi;
    chk_en = 1'b0;
    @(posedge clk); #1;
    i_first_address = first;
    i_last_address  = last;
    i_start = 1'b1;
    i_ready = rdy;
    @(posedge clk); #1;
    i_start = 1'b0;
    exp_q.delete();
    model_sum = 16'h0000;
    hi = (last > 8'd15) ? 15 : int'(last);
    for (int a = int'(first); a <= hi; a++) exp_q.push_back({8'(a), ram[a]});
    done_due = (exp_q.size() == 0);
    chk_en = 1'b1;
  endtask

  task automatic dump(input logic [7:0] first, input logic [7:0] last, input bit stall,
                      input bit poke, input logic [15:0] exp_sum, input string tag);
    int cyc, wait_cnt, n, first_seen;
    begin_dump(first, last, !stall);
    n = exp_q.size();
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
    cyc = 0; wait_cnt = 0; first_seen = -1;
    while (!o_done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (o_valid && first_seen < 0) first_seen = cyc;
      if (poke) begin
        if (cyc == 2) begin
          i_start = 1'b1; i_first_address = 8'd0; i_last_address = 8'd3;
        end else begin
          i_start = 1'b0;
        end
      end
      if (stall && o_valid) begin
        if (wait_cnt < 3) begin i_ready = 1'b0; wait_cnt++; end
        else begin i_ready = 1'b1; wait_cnt = 0; end
      end
    end
    i_start = 1'b0;
    chk({tag, "_done_seen"}, 32'(o_done), 32'd1);
    chk({tag, "_cycles"}, 32'(cyc), 32'(n * (stall ? 5 : 2)));
    if (n > 0) chk({tag, "_latency"}, 32'(first_seen), 32'd1);
    chk({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_sum"}, 32'(o_checksum), 32'(exp_sum));
    chk({tag, "_model_sum"}, 32'(model_sum), 32'(exp_sum));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    chk({tag, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int cyc;
    ram[0] = 16'h00FF; ram[1] = 16'h017F; ram[2] = 16'h0201; ram[3] = 16'h0702;
    for (int i = 4; i < 16; i++) ram[i] = 16'(i * 16'h0111);
    ram[14] = 16'hA5A5; ram[15] = 16'h1234;
    chk_en = 1'b0; done_due = 1'b0; model_sum = 16'h0000;
    i_reset = 1'b0; i_debug = 1'b0; i_start = 1'b1; i_abort = 1'b1; i_ready = 1'b1;
    i_first_address = 8'd0; i_last_address = 8'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_sum", 32'(o_checksum), 32'd0);
    chk("rst_ram_en", 32'(o_ram_read_enable), 32'd0);
    chk("rst_ram_addr", 32'(o_ram_address), 32'd0);
    i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0;

    dump(8'd0, 8'd3, 1'b0, 1'b0, 16'h0B81, "full");
    dump(8'd0, 8'd3, 1'b1, 1'b0, 16'h0B81, "stall");
    dump(8'd2, 8'd2, 1'b0, 1'b0, 16'h0201, "single");
    dump(8'd3, 8'd1, 1'b0, 1'b0, 16'h0000, "empty");
    dump(8'd14, 8'd200, 1'b0, 1'b1, 16'hB7D9, "clamp");

    begin_dump(8'd0, 8'd3, 1'b1);
    cyc = 0;
    while (!(o_valid && o_address == 8'd1) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_reach_w1", 32'(o_address), 32'd1);
    chk_en = 1'b0;
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_valid", 32'(o_valid), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_sum", 32'(o_checksum), 32'h00FF);
    chk("abort_model_sum", 32'(model_sum), 32'h00FF);
    @(posedge clk); #1;
    chk("abort_no_done", 32'(o_done), 32'd0);
    chk("abort_sum_kept", 32'(o_checksum), 32'h00FF);

    begin_dump(8'd0, 8'd3, 1'b0);
    cyc = 0;
    while (!o_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst2_in_send", 32'(o_valid), 32'd1);
    chk_en = 1'b0;
    i_reset = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b1;
    chk("rst2_valid", 32'(o_valid), 32'd0);
    chk("rst2_data", 32'(o_data), 32'd0);
    chk("rst2_addr", 32'(o_address), 32'd0);
    chk("rst2_busy", 32'(o_busy), 32'd0);
    chk("rst2_done", 32'(o_done), 32'd0);
    chk("rst2_sum", 32'(o_checksum), 32'd0);
    chk("rst2_ram_en", 32'(o_ram_read_enable), 32'd0);
    chk("rst2_ram_addr", 32'(o_ram_address), 32'd0);
    i_ready = 1'b1;
    dump(8'd0, 8'd3, 1'b0, 1'b0, 16'h0B81, "after_rst");

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
